// File: rtl/maxnet_scheduler_if.sv
// Requester/datapath bundle for maxnet_scheduler.
// master: the scheduler side; slave: the requesters, the status source and the datapath.
interface maxnet_scheduler_if #(
  parameter int unsigned ITER_W = 4
) ();
  logic              req0;
  logic              req1;
  logic [19:0]       data0;
  logic [19:0]       data1;
  logic              s;
  logic              gnt0;
  logic              gnt1;
  logic [4:0]        x1;
  logic [4:0]        x2;
  logic [4:0]        x3;
  logic [4:0]        x4;
  logic              input_en;
  logic              load_in;
  logic              sel_old_or_new;
  logic              mul_en;
  logic              sum_en;
  logic              done;
  logic              done_id;
  logic              busy;
  logic              timeout;
  logic [ITER_W-1:0] iter_cnt;

  modport master (
    input  req0, req1, data0, data1, s,
    output gnt0, gnt1, x1, x2, x3, x4,
    output input_en, load_in, sel_old_or_new, mul_en, sum_en,
    output done, done_id, busy, timeout, iter_cnt
  );

  modport slave (
    output req0, req1, data0, data1, s,
    input  gnt0, gnt1, x1, x2, x3, x4,
    input  input_en, load_in, sel_old_or_new, mul_en, sum_en,
    input  done, done_id, busy, timeout, iter_cnt
  );
endinterface

// File: rtl/maxnet_scheduler.sv
// Round-robin two-requester MAXNET job scheduler (LOAD, then MUL/SUM/UPDATE/CHECK per iteration, then FIN).
// Define MAXNET_SCHED_TIMEOUT_EN to end a job with timeout=1 once iter_cnt reaches MAX_ITER.
module maxnet_scheduler #(
  parameter int unsigned MAX_ITER = 15,
  parameter int unsigned ITER_W   = 4
) (
  input logic          clk,
  input logic          rst,
  maxnet_scheduler_if.master bus
);

`ifdef MAXNET_SCHED_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, MUL, SUM, UPDATE, CHECK, FIN} state_t;

  typedef struct packed {
    logic gnt0;
    logic gnt1;
    logic input_en;
    logic load_in;
    logic sel_old_or_new;
    logic mul_en;
    logic sum_en;
    logic done;
    logic done_id;
    logic busy;
    logic timeout;
  } ctl_t;

  state_t            state, state_d;
  logic              owner, owner_d;
  logic              last, last_d;
  logic [ITER_W-1:0] iter, iter_d;
  ctl_t              ctl, ctl_d;
  logic              hit_limit;
  logic              to_d;
  logic [19:0]       sel_data;

  // Constant-folds to 0 when the iteration limit is not built in.
  assign hit_limit = TIMEOUT_EN && (iter == ITER_W'(MAX_ITER));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      iter  <= '0;
      ctl   <= '0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      last  <= last_d;
      iter  <= iter_d;
      ctl   <= ctl_d;
    end
  end

  // Next state plus outputs decoded from the next state, so the output flops track the state register.
  always_comb begin
    state_d = state;
    owner_d = owner;
    last_d  = last;
    iter_d  = iter;
    to_d    = 1'b0;
    ctl_d   = '0;

    unique case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = LOAD;
          owner_d = (bus.req0 && bus.req1) ? ~last : bus.req1;
          iter_d  = '0;
        end
      end
      LOAD:   state_d = MUL;
      MUL:    state_d = SUM;
      SUM:    state_d = UPDATE;
      UPDATE: begin
        state_d = CHECK;
        iter_d  = iter + ITER_W'(1);
      end
      CHECK: begin
        if (bus.s) begin
          state_d = FIN;
        end else if (hit_limit) begin
          state_d = FIN;
          to_d    = 1'b1;
        end else begin
          state_d = MUL;
        end
      end
      FIN: begin
        state_d = IDLE;
        last_d  = owner;
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      LOAD: begin
        ctl_d.input_en = 1'b1;
        ctl_d.load_in  = 1'b1;
      end
      MUL: begin
        ctl_d.mul_en         = 1'b1;
        ctl_d.sel_old_or_new = 1'b1;
      end
      SUM: begin
        ctl_d.sum_en         = 1'b1;
        ctl_d.sel_old_or_new = 1'b1;
      end
      UPDATE: begin
        ctl_d.load_in        = 1'b1;
        ctl_d.sel_old_or_new = 1'b1;
      end
      FIN: begin
        ctl_d.done    = 1'b1;
        ctl_d.done_id = owner_d;
        ctl_d.timeout = to_d;
      end
      default: ;
    endcase

    ctl_d.busy = (state_d != IDLE);
    ctl_d.gnt0 = ctl_d.busy && !owner_d;
    ctl_d.gnt1 = ctl_d.busy && owner_d;
  end

  // Datapath operands come straight from the granted requester.
  assign sel_data = ctl.gnt0 ? bus.data0 : (ctl.gnt1 ? bus.data1 : 20'd0);

  assign bus.x1             = sel_data[4:0];
  assign bus.x2             = sel_data[9:5];
  assign bus.x3             = sel_data[14:10];
  assign bus.x4             = sel_data[19:15];
  assign bus.gnt0           = ctl.gnt0;
  assign bus.gnt1           = ctl.gnt1;
  assign bus.input_en       = ctl.input_en;
  assign bus.load_in        = ctl.load_in;
  assign bus.sel_old_or_new = ctl.sel_old_or_new;
  assign bus.mul_en         = ctl.mul_en;
  assign bus.sum_en         = ctl.sum_en;
  assign bus.done           = ctl.done;
  assign bus.done_id        = ctl.done_id;
  assign bus.busy           = ctl.busy;
  assign bus.timeout        = ctl.timeout;
  assign bus.iter_cnt       = iter;

endmodule

// File: tb/tb_maxnet_scheduler.sv
// Bench for maxnet_scheduler: directed job sequences, a job table and random traffic,
// all checked every cycle against a job-position reference model.
module tb_maxnet_scheduler;
  localparam int unsigned MAX_ITER = 3;
  localparam int unsigned ITER_W   = 4;
`ifdef MAXNET_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maxnet_scheduler_if #(.ITER_W(ITER_W)) bus ();

  maxnet_scheduler #(.MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a job is a position count from LOAD (0); FIN is flagged once a CHECK ends the job.
  bit m_busy, m_fin, m_owner, m_last, m_to;
  int m_pos, m_iter;

  logic [4:0] ctl_log [0:300];
  logic [1:0] gnt_log [0:300];

  typedef struct {
    bit r0;
    bit r1;
    int k;
    bit exp_id;
    int exp_cycles;
    int exp_iter;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return 64'({bus.gnt0, bus.gnt1, bus.x1, bus.x2, bus.x3, bus.x4,
                bus.input_en, bus.load_in, bus.sel_old_or_new, bus.mul_en, bus.sum_en,
                bus.done, bus.done_id, bus.busy, bus.timeout, bus.iter_cnt});
  endfunction

  function automatic logic [63:0] model_vec();
    logic g0, g1, ie, li, sl, mu, su, dn, di, to;
    logic [19:0] xd;
    logic [ITER_W-1:0] it;
    int ph;
    {g0, g1, ie, li, sl, mu, su, dn, di, to} = '0;
    xd = '0;
    it = m_iter[ITER_W-1:0];
    if (m_busy) begin
      g0 = !m_owner;
      g1 = m_owner;
      xd = m_owner ? bus.data1 : bus.data0;
      if (m_fin) begin
        dn = 1'b1;
        di = m_owner;
        to = m_to;
      end else if (m_pos == 0) begin
        ie = 1'b1;
        li = 1'b1;
      end else begin
        ph = (m_pos - 1) % 4;
        case (ph)
          0: begin mu = 1'b1; sl = 1'b1; end
          1: begin su = 1'b1; sl = 1'b1; end
          2: begin li = 1'b1; sl = 1'b1; end
          default: ;
        endcase
      end
    end
    return 64'({g0, g1, xd[4:0], xd[9:5], xd[14:10], xd[19:15],
                ie, li, sl, mu, su, dn, di, m_busy, to, it});
  endfunction

  task automatic model_step();
    int ph;
    if (rst) begin
      m_busy = 0; m_fin = 0; m_last = 1; m_iter = 0; m_to = 0; m_pos = 0;
    end else if (!m_busy) begin
      if (bus.req0 || bus.req1) begin
        m_owner = (bus.req0 && bus.req1) ? !m_last : bus.req1;
        m_busy = 1; m_pos = 0; m_iter = 0; m_fin = 0; m_to = 0;
      end
    end else if (m_fin) begin
      m_busy = 0; m_fin = 0; m_last = m_owner;
    end else begin
      if (m_pos > 0) begin
        ph = (m_pos - 1) % 4;
        if (ph == 2) m_iter++;
        if (ph == 3) begin
          if (bus.s) m_fin = 1;
          else if (TO_EN && m_iter == int'(MAX_ITER)) begin
            m_fin = 1;
            m_to = 1;
          end
        end
      end
      m_pos++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("cycle_outputs", dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Runs from cycle n0 (0 = IDLE with requests up) until done; s=1 only at the k-th CHECK (k=0: never).
  task automatic run_to_done(input int k, input int n0, input int drop_at, output int n);
    bit got;
    got = 0;
    n = n0;
    while (!got && n < n0 + 250) begin
      if (n == drop_at) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      if (n >= 5 && (n - 1) % 4 == 0) bus.s = (k > 0 && n == 4 * k + 1);
      else bus.s = 1'($urandom);
      tick();
      n++;
      if (n <= 300) begin
        ctl_log[n] = {bus.input_en, bus.load_in, bus.sel_old_or_new, bus.mul_en, bus.sum_en};
        gnt_log[n] = {bus.gnt0, bus.gnt1};
      end
      if (bus.done === 1'b1) got = 1;
    end
    if (!got) chk("done_seen", 64'(0), 64'(1));
  endtask

  initial begin
    int n;
    vec_t vt [6];
    logic [4:0] exp_ctl [1:10];

    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.s = 1'b0;
    bus.data0 = '0; bus.data1 = '0;

    // Reset state
    do_reset();
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_iter", 64'(bus.iter_cnt), 64'(0));
    chk("rst_gnt", 64'({bus.gnt0, bus.gnt1}), 64'(0));

    // Single requester, one iteration
    bus.data0 = 20'($urandom);
    bus.req0 = 1'b1;
    run_to_done(1, 0, 1, n);
    chk("t1_gnt_load", 64'(gnt_log[1]), 64'(2'b10));
    chk("t1_done_cycle", 64'(n), 64'(6));
    chk("t1_done_id", 64'(bus.done_id), 64'(0));
    chk("t1_iter", 64'(bus.iter_cnt), 64'(1));
    chk("t1_timeout", 64'(bus.timeout), 64'(0));
    tick();

    // Both held: alternating grants, one IDLE cycle between jobs
    do_reset();
    bus.data0 = 20'($urandom);
    bus.data1 = 20'($urandom);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      run_to_done(1, 0, -1, n);
      chk("t2_gnt_order", 64'(gnt_log[1]), (j % 2 == 1) ? 64'(2'b01) : 64'(2'b10));
      chk("t2_done_cycle", 64'(n), 64'(6));
      if (j == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      tick();
      chk("t2_idle_gap", 64'(bus.busy), 64'(0));
    end

    // s held low
    do_reset();
    bus.data0 = 20'($urandom);
    bus.req0 = 1'b1;
`ifdef MAXNET_SCHED_TIMEOUT_EN
    run_to_done(0, 0, 1, n);
    chk("t3_done_cycle", 64'(n), 64'(14));
    chk("t3_timeout", 64'(bus.timeout), 64'(1));
    chk("t3_iter", 64'(bus.iter_cnt), 64'(3));
`else
    run_to_done(17, 0, 1, n);
    chk("t3_done_cycle", 64'(n), 64'(70));
    chk("t3_timeout", 64'(bus.timeout), 64'(0));
    chk("t3_iter_wrap", 64'(bus.iter_cnt), 64'(1));
`endif
    tick();

    // Reset during SUM
    do_reset();
    bus.req0 = 1'b1;
    run_to_done(1, 0, 1, n);
    tick();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    tick();
    chk("t4_rr_gnt", 64'({bus.gnt0, bus.gnt1}), 64'(2'b01));
    tick();
    tick();
    chk("t4_in_sum", 64'(bus.sum_en), 64'(1));
    rst = 1'b1;
    tick();
    chk("t4_reset_outputs", dut_vec(), 64'(0));
    rst = 1'b0;
    tick();
    chk("t4_post_rst_gnt", 64'({bus.gnt0, bus.gnt1}), 64'(2'b10));
    chk("t4_no_done", 64'(bus.done), 64'(0));
    run_to_done(1, 1, 1, n);
    chk("t4_done_cycle", 64'(n), 64'(6));
    chk("t4_done_id", 64'(bus.done_id), 64'(0));
    tick();
    do_reset();
    bus.req1 = 1'b1;
    tick();
    chk("t4_req1_alone", 64'({bus.gnt0, bus.gnt1}), 64'(2'b01));
    run_to_done(1, 1, 1, n);
    chk("t4_req1_done_id", 64'(bus.done_id), 64'(1));
    tick();

    // req1 drops in MUL, two iterations, controls per cycle
    exp_ctl = '{5'b11000, 5'b00110, 5'b00101, 5'b01100, 5'b00000,
                5'b00110, 5'b00101, 5'b01100, 5'b00000, 5'b00000};
    do_reset();
    bus.data1 = 20'($urandom);
    bus.req1 = 1'b1;
    run_to_done(2, 0, 2, n);
    chk("t5_done_cycle", 64'(n), 64'(10));
    chk("t5_done_id", 64'(bus.done_id), 64'(1));
    chk("t5_iter", 64'(bus.iter_cnt), 64'(2));
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("t5_ctl_c%0d", c), 64'(ctl_log[c]), 64'(exp_ctl[c]));
      chk($sformatf("t5_gnt_c%0d", c), 64'(gnt_log[c]), 64'(2'b01));
    end
    tick();
    chk("t5_idle", 64'(bus.busy), 64'(0));

    // Job table; pointer state carries from row to row
    vt[0] = '{r0: 1, r1: 0, k: 1, exp_id: 0, exp_cycles: 6,  exp_iter: 1};
    vt[1] = '{r0: 1, r1: 1, k: 2, exp_id: 1, exp_cycles: 10, exp_iter: 2};
    vt[2] = '{r0: 1, r1: 1, k: 3, exp_id: 0, exp_cycles: 14, exp_iter: 3};
    vt[3] = '{r0: 1, r1: 0, k: 1, exp_id: 0, exp_cycles: 6,  exp_iter: 1};
    vt[4] = '{r0: 0, r1: 1, k: 2, exp_id: 1, exp_cycles: 10, exp_iter: 2};
    vt[5] = '{r0: 1, r1: 1, k: 1, exp_id: 0, exp_cycles: 6,  exp_iter: 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.data0 = 20'($urandom);
      bus.data1 = 20'($urandom);
      bus.req0 = vt[i].r0;
      bus.req1 = vt[i].r1;
      run_to_done(vt[i].k, 0, 2, n);
      chk($sformatf("tab%0d_cycles", i), 64'(n), 64'(vt[i].exp_cycles));
      chk($sformatf("tab%0d_id", i), 64'(bus.done_id), 64'(vt[i].exp_id));
      chk($sformatf("tab%0d_iter", i), 64'(bus.iter_cnt), 64'(vt[i].exp_iter));
      chk($sformatf("tab%0d_timeout", i), 64'(bus.timeout), 64'(0));
      tick();
    end

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.req0  = ($urandom % 4 == 0);
      bus.req1  = ($urandom % 4 == 0);
      bus.data0 = 20'($urandom);
      bus.data1 = 20'($urandom);
      bus.s     = ($urandom % 3 == 0);
      rst       = ($urandom % 97 == 0);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/maxnet_scheduler.md
MAXNET_SCHEDULER -- requirements
Module: maxnet_scheduler

Interface
REQ-001 The block SHALL have parameter MAX_ITER, default 15, giving the iteration limit per job (1..2^ITER_W-1).
REQ-002 The block SHALL have parameter ITER_W, default 4, giving the iteration counter width.
REQ-003 The block SHALL have one clock and a synchronous active-high reset: port clk, input, 1, rising-edge clock.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port req0 / req1, input, 1 each: job request from requester 0 / 1.
REQ-006 Port data0 / data1, input, 20 each: four packed 5-bit values; bits [4:0] are x1 and [19:15] are x4.
REQ-007 Port s, input, 1: datapath status; high means at most one nonzero PU output remains.
REQ-008 Port gnt0 / gnt1, output, 1 each: requester owns the datapath.
REQ-009 Port x1..x4, output, 5 each: granted requester's values muxed to the datapath.
REQ-010 Port input_en, load_in, sel_old_or_new, mul_en, sum_en, output, 1 each: datapath controls.
REQ-011 Port done, output, 1: one-cycle job-complete pulse.
REQ-012 Port done_id, output, 1: requester served by the job, valid with done.
REQ-013 Port busy, output, 1: state is not IDLE.
REQ-014 Port timeout, output, 1: job ended on the iteration limit; valid with done.
REQ-015 Port iter_cnt, output, ITER_W: completed iterations in the current or last job.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, MUL, SUM, UPDATE, CHECK and FIN; all outputs are decoded from registered state (Moore).
REQ-017 IDLE with any req high SHALL move to LOAD on the next edge and assert the winner's gnt from that cycle.
REQ-018 Arbitration SHALL be round-robin: when both requests are high, the requester not served last wins; after reset, requester 0 has priority.
REQ-019 The grant SHALL hold from LOAD through FIN inclusive; x1..x4 SHALL follow the granted data while gnt is high and are 0 otherwise.
REQ-020 LOAD SHALL last 1 cycle with input_en=1, load_in=1 and sel_old_or_new=0; it clears iter_cnt and then moves to MUL.
REQ-021 MUL SHALL assert mul_en=1 and sel_old_or_new=1 for 1 cycle, then move to SUM.
REQ-022 SUM SHALL assert sum_en=1 and sel_old_or_new=1 for 1 cycle, then move to UPDATE.
REQ-023 UPDATE SHALL assert load_in=1 and sel_old_or_new=1 for 1 cycle, increment iter_cnt, then move to CHECK.
REQ-024 CHECK SHALL sample s: s=1 moves to FIN with timeout=0; otherwise it loops back to MUL, subject to REQ-032.
REQ-025 FIN SHALL last 1 cycle with done=1 and done_id set, drop the grant, update the round-robin pointer, then move to IDLE.
REQ-026 A job of k iterations SHALL take exactly 4k+2 cycles from LOAD to FIN inclusive.
REQ-027 Any control output not listed for a state SHALL be 0.
REQ-028 A requester deasserting req during its job SHALL be ignored; the job completes.
REQ-029 A request held high through FIN SHALL be re-arbitrated in IDLE; the other pending requester wins.
REQ-030 s SHALL be ignored outside CHECK.

Reset
REQ-031 When rst=1 at an edge, the next state SHALL be IDLE with every output 0, iter_cnt=0 and the round-robin pointer set to favour requester 0; this applies mid-job too, and no done is issued for an aborted job.

Configuration
REQ-032 With MAXNET_SCHED_TIMEOUT_EN defined, CHECK with s=0 and iter_cnt==MAX_ITER SHALL move to FIN with timeout=1.
REQ-033 Without MAXNET_SCHED_TIMEOUT_EN, CHECK SHALL loop until s=1, timeout SHALL be tied 0, and iter_cnt SHALL wrap modulo 2^ITER_W.

Verification
REQ-034 The bench SHALL cover: req0=1 with data0 and s=1 at the first CHECK -> gnt0 next cycle, done in cycle 6, done_id=0, iter_cnt=1, timeout=0.
REQ-035 The bench SHALL cover: req0=req1=1 held continuously -> grant order 0,1,0,1 with exactly one IDLE cycle between jobs.
REQ-036 The bench SHALL cover: s=0 forever, macro defined, MAX_ITER=3 -> done at cycle 14, timeout=1, iter_cnt=3.
REQ-037 The bench SHALL cover: rst pulsed while in SUM -> next cycle IDLE, all outputs 0, no done, and req1 favoured only if req0 is low.
REQ-038 The bench SHALL cover: req1 dropped in MUL with s=1 at the second CHECK -> job completes, done_id=1, iter_cnt=2; control sequences checked cycle-by-cycle.
